// File: rtl/sextium_pkg.sv
// Shared definitions for the Sextium III core: opcodes, syscall codes and FSM states.
package sextium_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_SYSCALL = 4'h1;
    localparam logic [3:0] OP_LOAD    = 4'h2;
    localparam logic [3:0] OP_STORE   = 4'h3;
    localparam logic [3:0] OP_SWAPA   = 4'h4;
    localparam logic [3:0] OP_SWAPD   = 4'h5;
    localparam logic [3:0] OP_BRANCHZ = 4'h6;
    localparam logic [3:0] OP_BRANCHN = 4'h7;
    localparam logic [3:0] OP_JUMP    = 4'h8;
    localparam logic [3:0] OP_CONST   = 4'h9;
    localparam logic [3:0] OP_ADD     = 4'hA;
    localparam logic [3:0] OP_SUB     = 4'hB;
    localparam logic [3:0] OP_MUL     = 4'hC;
    localparam logic [3:0] OP_DIV     = 4'hD;
    localparam logic [3:0] OP_SHIFT   = 4'hE;
    localparam logic [3:0] OP_NAND    = 4'hF;

    localparam logic [15:0] SYS_HALT  = 16'd0;
    localparam logic [15:0] SYS_READ  = 16'd1;
    localparam logic [15:0] SYS_WRITE = 16'd2;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_IO_WAIT,
        ST_HALT
    } state_t;

endpackage

// File: rtl/sextium_alu.sv
// Combinational arithmetic/logic unit of the Sextium III core, operating on ACC and DR.
module sextium_alu
    import sextium_pkg::*;
(
    input  logic [15:0] i_acc,
    input  logic [15:0] i_dr,
    input  logic [3:0]  i_op,
    output logic [15:0] o_result
);

    logic signed [16:0] w_num;
    logic signed [16:0] w_den;
    logic        [15:0] w_quot;
    logic        [15:0] w_prod;

    // Shift by a signed amount: positive shifts left, negative shifts right logically.
    function automatic logic [15:0] shift_val(input logic [15:0] a, input logic [15:0] d);
        logic [16:0] mag;
        mag = 17'd0 - {d[15], d};
        if (!d[15])
            shift_val = (d >= 16'd16) ? 16'd0 : (a << d[3:0]);
        else
            shift_val = (mag >= 17'd16) ? 16'd0 : (a >> mag[3:0]);
    endfunction

    // Low half of a two's-complement product is independent of operand signedness.
    assign w_prod = i_acc * i_dr;

    // Sign-extend to 17 bits so -32768 / -1 wraps to 0x8000 instead of overflowing.
    assign w_num  = {i_acc[15], i_acc};
    assign w_den  = (i_dr == 16'd0) ? 17'sd1 : {i_dr[15], i_dr};
    assign w_quot = 16'(w_num / w_den);

    always_comb begin
        o_result = i_acc;
        case (i_op)
            OP_ADD:   o_result = i_acc + i_dr;
            OP_SUB:   o_result = i_acc - i_dr;
            OP_MUL:   o_result = w_prod;
            OP_DIV:   o_result = (i_dr == 16'd0) ? i_acc : w_quot;
            OP_SHIFT: o_result = shift_val(i_acc, i_dr);
            OP_NAND:  o_result = ~(i_acc & i_dr);
            default:  o_result = i_acc;
        endcase
    end

endmodule

// File: rtl/sextium_iii_core.sv
// Sextium III 16-bit accumulator CPU: fetches four-nibble words and executes them MSB first.
module sextium_iii_core
    import sextium_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ioack,
    input  logic [15:0] io_bus_in,
    output logic [15:0] io_bus_out,
    input  logic [15:0] mem_bus_in,
    output logic [15:0] mem_bus_out,
    output logic [15:0] addr_bus,
    output logic        mem_read,
    output logic        mem_write,
    output logic        io_read,
    output logic        io_write
);

    logic [15:0] r_acc;
    logic [15:0] r_ar;
    logic [15:0] r_dr;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [1:0]  r_slot;
    state_t      r_state;

    logic [3:0]  w_op;
    logic [15:0] w_alu;
    logic        w_last;
    logic        w_sys_io;

    always_comb begin
        case (r_slot)
            2'd0:    w_op = r_ir[15:12];
            2'd1:    w_op = r_ir[11:8];
            2'd2:    w_op = r_ir[7:4];
            default: w_op = r_ir[3:0];
        endcase
    end

    assign w_last = (r_slot == 2'd3);

    sextium_alu u_alu (
        .i_acc    (r_acc),
        .i_dr     (r_dr),
        .i_op     (w_op),
        .o_result (w_alu)
    );

    // The SYSCALL execute cycle is already the first strobe cycle; IO_WAIT just holds it.
    assign w_sys_io   = !reset && (r_state == ST_EXEC || r_state == ST_IO_WAIT)
                        && (w_op == OP_SYSCALL);
    assign io_read    = w_sys_io && (r_acc == SYS_READ);
    assign io_write   = w_sys_io && (r_acc == SYS_WRITE);
    assign io_bus_out = io_write ? r_dr : 16'd0;

    always_comb begin
        addr_bus    = 16'd0;
        mem_bus_out = 16'd0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        if (!reset) begin
            if (r_state == ST_FETCH) begin
                mem_read = 1'b1;
                addr_bus = r_pc;
            end else if (r_state == ST_EXEC) begin
                case (w_op)
                    OP_LOAD: begin
                        mem_read = 1'b1;
                        addr_bus = r_ar;
                    end
                    OP_STORE: begin
                        mem_write   = 1'b1;
                        addr_bus    = r_ar;
                        mem_bus_out = r_acc;
                    end
                    OP_CONST: begin
                        mem_read = 1'b1;
                        addr_bus = r_pc;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc   <= 16'd0;
            r_ar    <= 16'd0;
            r_dr    <= 16'd0;
            r_pc    <= 16'd0;
            r_ir    <= 16'd0;
            r_slot  <= 2'd0;
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= mem_bus_in;
                    r_pc    <= r_pc + 16'd1;
                    r_slot  <= 2'd0;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Default: advance to the next nibble; individual opcodes override below.
                    r_slot  <= r_slot + 2'd1;
                    r_state <= w_last ? ST_FETCH : ST_EXEC;
                    case (w_op)
                        OP_SYSCALL: begin
                            if (r_acc == SYS_HALT) begin
                                r_state <= ST_HALT;
                            end else if (r_acc == SYS_READ || r_acc == SYS_WRITE) begin
                                if (ioack) begin
                                    if (r_acc == SYS_READ)
                                        r_acc <= io_bus_in;
                                end else begin
                                    r_slot  <= r_slot;
                                    r_state <= ST_IO_WAIT;
                                end
                            end
                        end
                        OP_LOAD:  r_acc <= mem_bus_in;
                        OP_SWAPA: begin
                            r_acc <= r_ar;
                            r_ar  <= r_acc;
                        end
                        OP_SWAPD: begin
                            r_acc <= r_dr;
                            r_dr  <= r_acc;
                        end
                        OP_BRANCHZ: begin
                            if (r_acc == 16'd0) begin
                                r_pc    <= r_ar;
                                r_state <= ST_FETCH;
                            end
                        end
                        OP_BRANCHN: begin
                            if (r_acc[15]) begin
                                r_pc    <= r_ar;
                                r_state <= ST_FETCH;
                            end
                        end
                        OP_JUMP: begin
                            r_pc    <= r_acc;
                            r_state <= ST_FETCH;
                        end
                        OP_CONST: begin
                            r_acc <= mem_bus_in;
                            r_pc  <= r_pc + 16'd1;
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHIFT, OP_NAND:
                            r_acc <= w_alu;
                        default: ;
                    endcase
                end
                ST_IO_WAIT: begin
                    if (ioack) begin
                        if (r_acc == SYS_READ)
                            r_acc <= io_bus_in;
                        r_slot  <= r_slot + 2'd1;
                        r_state <= w_last ? ST_FETCH : ST_EXEC;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sextium_iii_core.sv
// Self-checking bench for sextium_iii_core: directed program scenarios plus random programs vs an ISA-level model.
module tb_sextium_iii_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ioack = 1'b0;
    logic [15:0] io_bus_in = 16'd0;
    logic [15:0] io_bus_out;
    logic [15:0] mem_bus_in;
    logic [15:0] mem_bus_out;
    logic [15:0] addr_bus;
    logic        mem_read, mem_write, io_read, io_write;

    logic [15:0] mem  [0:65535];
    logic [15:0] rmem [0:65535];
    int          dly  [0:255];
    logic [15:0] rv   [0:255];

    localparam int K_R = 1, K_W = 2, K_IOW = 3, K_IOR = 4;

    typedef struct packed {
        logic [15:0] cyc;
        logic [15:0] kind;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc, k_dev, in_txn, cnt, last_strobe, excl_viol, iow_cycles;

    always #5 clock = ~clock;

    assign mem_bus_in = mem[addr_bus];

    sextium_iii_core dut (
        .clock       (clock),
        .reset       (reset),
        .ioack       (ioack),
        .io_bus_in   (io_bus_in),
        .io_bus_out  (io_bus_out),
        .mem_bus_in  (mem_bus_in),
        .mem_bus_out (mem_bus_out),
        .addr_bus    (addr_bus),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .io_read     (io_read),
        .io_write    (io_write)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ev_t mk(input int c, input int k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.cyc  = 16'(c);
        e.kind = 16'(k);
        e.a    = a;
        e.d    = d;
        return e;
    endfunction

    // One clock cycle: device/memory models respond, bus activity is logged, then the edge.
    task automatic step();
        logic        wm, ack_now;
        logic [15:0] wa, wd;
        if (io_read || io_write) begin
            if (in_txn == 0) begin
                in_txn = 1;
                cnt    = dly[k_dev & 255];
            end
            io_bus_in = rv[k_dev & 255];
            ioack     = (cnt == 0);
            if (cnt > 0) cnt--;
        end else begin
            ioack     = 1'($urandom_range(0, 1));
            io_bus_in = 16'($urandom);
        end
        #1;
        if (mem_read)            obs_q.push_back(mk(cyc, K_R, addr_bus, 16'd0));
        if (mem_write)           obs_q.push_back(mk(cyc, K_W, addr_bus, mem_bus_out));
        if (io_write && ioack)   obs_q.push_back(mk(cyc, K_IOW, 16'd0, io_bus_out));
        if (io_read && ioack)    obs_q.push_back(mk(cyc, K_IOR, 16'd0, io_bus_in));
        if (mem_read || mem_write || io_read || io_write) last_strobe = cyc;
        if ((mem_read && mem_write) || (io_read && io_write)) excl_viol++;
        if (io_write) iow_cycles++;
        wm      = mem_write;
        wa      = addr_bus;
        wd      = mem_bus_out;
        ack_now = ioack && (io_read || io_write);
        @(posedge clock);
        if (wm) mem[wa] = wd;
        if (ack_now) begin
            in_txn = 0;
            k_dev++;
        end
        cyc++;
        #1;
    endtask

    task automatic run_dut(input int cycles);
        obs_q.delete();
        cyc = 0; k_dev = 0; in_txn = 0; cnt = 0;
        last_strobe = -1; excl_viol = 0; iow_cycles = 0;
        reset = 1'b1; ioack = 1'b0; io_bus_in = 16'd0;
        @(posedge clock);
        #1;
        chk("reset_outputs", {addr_bus, io_bus_out, mem_bus_out, 12'd0,
                              mem_read, mem_write, io_read, io_write}, 64'd0);
        reset = 1'b0;
        repeat (cycles) step();
        chk("strobe_exclusive", excl_viol, 0);
    endtask

    task automatic clear_mem();
        foreach (mem[i]) begin
            mem[i]  = 16'd0;
            rmem[i] = 16'd0;
        end
    endtask

    task automatic load(input logic [15:0] w0, w1, w2, w3, w4);
        clear_mem();
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4;
    endtask

    task automatic exp_ev(input string tag, input int idx, input int c, input int k,
                          input logic [15:0] a, input logic [15:0] d);
        ev_t got;
        got = (idx < obs_q.size()) ? obs_q[idx] : '1;
        chk(tag, got, mk(c, k, a, d));
    endtask

    task automatic alu_case(input string tag, input logic [15:0] a, input logic [15:0] d,
                            input logic [3:0] op, input logic [15:0] res);
        load({4'h9, 4'h5, 4'h9, op}, d, a, 16'h3910, 16'h0000);
        run_dut(20);
        exp_ev(tag, 4, 6, K_W, 16'h0000, res);
    endtask

    // Instruction-level reference: walks the program, predicting each bus transaction and its cycle.
    task automatic run_model(input int limit);
        logic [15:0] acc, ar, dr, pc, ir, t;
        logic [3:0]  op;
        int          c, k, sa, sd, p;
        bit          halted, jumped;
        acc = 0; ar = 0; dr = 0; pc = 0; c = 0; k = 0; halted = 0;
        exp_q.delete();
        while (c < limit && !halted) begin
            exp_q.push_back(mk(c, K_R, pc, 16'd0));
            ir = rmem[pc];
            pc = pc + 16'd1;
            c++;
            for (int s = 0; s < 4 && !halted && c < limit; s++) begin
                op = ir[15 - 4*s -: 4];
                jumped = 0;
                sa = int'($signed(acc));
                sd = int'($signed(dr));
                case (op)
                    4'h1: begin
                        if (acc == 0) halted = 1;
                        else if (acc == 1 || acc == 2) begin
                            c += dly[k & 255];
                            if (acc == 1) begin
                                exp_q.push_back(mk(c, K_IOR, 16'd0, rv[k & 255]));
                                acc = rv[k & 255];
                            end else begin
                                exp_q.push_back(mk(c, K_IOW, 16'd0, dr));
                            end
                            k++;
                        end
                    end
                    4'h2: begin exp_q.push_back(mk(c, K_R, ar, 16'd0)); acc = rmem[ar]; end
                    4'h3: begin exp_q.push_back(mk(c, K_W, ar, acc)); rmem[ar] = acc; end
                    4'h4: begin t = acc; acc = ar; ar = t; end
                    4'h5: begin t = acc; acc = dr; dr = t; end
                    4'h6: if (acc == 0) begin pc = ar; jumped = 1; end
                    4'h7: if (sa < 0) begin pc = ar; jumped = 1; end
                    4'h8: begin pc = acc; jumped = 1; end
                    4'h9: begin
                        exp_q.push_back(mk(c, K_R, pc, 16'd0));
                        acc = rmem[pc];
                        pc  = pc + 16'd1;
                    end
                    4'hA: acc = 16'(sa + sd);
                    4'hB: acc = 16'(sa - sd);
                    4'hC: begin p = sa * sd; acc = p[15:0]; end
                    4'hD: if (sd != 0) begin p = sa / sd; acc = p[15:0]; end
                    4'hE: begin
                        if (sd >= 16 || sd <= -16) acc = 16'd0;
                        else if (sd >= 0)          acc = acc << sd;
                        else                       acc = acc >> (-sd);
                    end
                    4'hF: acc = ~(acc & dr);
                    default: ;
                endcase
                c++;
                if (jumped) break;
            end
        end
        while (exp_q.size() > 0 && int'(exp_q[exp_q.size()-1].cyc) >= limit)
            void'(exp_q.pop_back());
    endtask

    initial begin
        foreach (dly[i]) begin
            dly[i] = 0;
            rv[i]  = 16'd0;
        end

        // CONST 5; ADD with DR=0; SYSCALL with ACC=5 is a NOP; store ACC; halt.
        load(16'h9A10, 16'h0005, 16'h3100, 16'h9100, 16'h0000);
        run_dut(40);
        exp_ev("t1_fetch0", 0, 0, K_R, 16'h0000, 16'h0000);
        exp_ev("t1_const", 1, 1, K_R, 16'h0001, 16'h0000);
        exp_ev("t1_fetch2", 2, 5, K_R, 16'h0002, 16'h0000);
        exp_ev("t1_store_acc", 3, 6, K_W, 16'h0000, 16'h0005);
        chk("t1_event_count", obs_q.size(), 6);
        chk("t1_halt_quiet", last_strobe, 11);

        // Write syscall with DR=0x1234, device acks after 3 wait cycles.
        dly[0] = 3;
        load(16'h9591, 16'h1234, 16'h0002, 16'h9100, 16'h0000);
        run_dut(30);
        exp_ev("t2_iowrite", 3, 7, K_IOW, 16'h0000, 16'h1234);
        exp_ev("t2_next_fetch", 4, 8, K_R, 16'h0003, 16'h0000);
        chk("t2_iow_cycles", iow_cycles, 4);

        // Reset in the middle of a pending write drops the strobe at once.
        dly[0] = 50;
        run_dut(6);
        chk("abort_pre", io_write, 1);
        reset = 1'b1;
        #1;
        chk("abort_drop", {io_read, io_write, io_bus_out}, 0);

        // Read syscall returning 0xBEEF, then STORE to AR=0x40.
        dly[0] = 0;
        rv[0]  = 16'hBEEF;
        load(16'h9491, 16'h0040, 16'h0001, 16'h3910, 16'h0000);
        run_dut(30);
        exp_ev("t3_ioread", 3, 4, K_IOR, 16'h0000, 16'hBEEF);
        exp_ev("t3_store", 5, 6, K_W, 16'h0040, 16'hBEEF);
        chk("t3_mem40", mem[16'h0040], 16'hBEEF);

        // BRANCHZ taken from slot 1; the two STOREs after it must not run.
        load(16'h9400, 16'h0010, 16'h0633, 16'h0000, 16'h0000);
        mem[16'h0010] = 16'h9100;
        run_dut(30);
        exp_ev("bz_target", 3, 8, K_R, 16'h0010, 16'h0000);
        chk("bz_event_count", obs_q.size(), 5);

        // BRANCHN taken with ACC=0x8000.
        load(16'h9497, 16'h0020, 16'h8000, 16'h0000, 16'h0000);
        mem[16'h0020] = 16'h9100;
        run_dut(20);
        exp_ev("bn_taken", 3, 5, K_R, 16'h0020, 16'h0000);

        // ACC=1: neither branch taken; the following STORE executes.
        load(16'h9496, 16'h0020, 16'h0001, 16'h7391, 16'h0000);
        run_dut(20);
        exp_ev("bz_not_taken", 3, 5, K_R, 16'h0003, 16'h0000);
        exp_ev("bn_not_taken", 4, 7, K_W, 16'h0020, 16'h0001);

        alu_case("alu_div_neg",   16'h0007, 16'hFFFE, 4'hD, 16'hFFFD);
        alu_case("alu_shr",       16'h00F0, 16'hFFFC, 4'hE, 16'h000F);
        alu_case("alu_shl_big",   16'h0001, 16'h0014, 4'hE, 16'h0000);
        alu_case("alu_nand",      16'hFFFF, 16'h00FF, 4'hF, 16'hFF00);
        alu_case("alu_div_zero",  16'h0009, 16'h0000, 4'hD, 16'h0009);
        alu_case("alu_mul_neg",   16'hFFFD, 16'h0005, 4'hC, 16'hFFF1);
        alu_case("alu_sub_wrap",  16'h0003, 16'h0005, 4'hB, 16'hFFFE);
        alu_case("alu_div_ovf",   16'h8000, 16'hFFFF, 4'hD, 16'h8000);

        // Random programs against the instruction-level model.
        for (int t = 0; t < 30; t++) begin
            clear_mem();
            for (int i = 0; i < 32; i++) begin
                mem[i] = 16'($urandom);
                if (($urandom & 3) == 0) mem[i] = 16'($urandom_range(0, 3));
                rmem[i] = mem[i];
            end
            foreach (dly[i]) begin
                dly[i] = $urandom_range(0, 4);
                rv[i]  = ($urandom & 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            end
            run_model(200);
            run_dut(200);
            chk("rnd_event_count", obs_q.size(), exp_q.size());
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                chk("rnd_event", obs_q[i], exp_q[i]);
                if (obs_q[i] !== exp_q[i]) break;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
